// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: debounced 3-bit mode select drives one of five
// tick-paced animations or a manual pass-through onto a registered LED bus.
module led_pattern_sequencer #(
   parameter int NUM_LEDS        = 4,
   parameter int TICK_DIV        = 25000000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [2:0]          sw_mode,
   input  logic [NUM_LEDS-1:0] sw_data,
   output logic [NUM_LEDS-1:0] led,
   output logic [2:0]          mode,
   output logic                mode_change
);

   typedef enum logic [2:0] {
      MODE_CYCLE  = 3'd0,
      MODE_LFSR   = 3'd1,
      MODE_BLINK  = 3'd2,
      MODE_BOUNCE = 3'd3,
      MODE_COUNT  = 3'd4,
      MODE_MAN5   = 3'd5,
      MODE_MAN6   = 3'd6,
      MODE_MAN7   = 3'd7
   } mode_e;

   localparam int                  TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int                  DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [TICK_W-1:0]   TICK_MAX  = TICK_W'(TICK_DIV - 1);
   localparam logic [DB_W-1:0]     DB_MAX    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [15:0]         LFSR_SEED = 16'hACE1;
   localparam logic [NUM_LEDS-1:0] BIT0      = NUM_LEDS'(1);

   logic [2:0]          sync_meta;
   logic [2:0]          sync_mode;
   logic [2:0]          sync_prev;
   logic [DB_W-1:0]     db_cnt;
   logic [TICK_W-1:0]   tick_cnt;
   mode_e               mode_q;
   logic                mode_load;
   logic                tick;
   logic [NUM_LEDS-1:0] cyc_pat;
   logic [NUM_LEDS-1:0] bnc_pat;
   logic                bnc_up;
   logic [NUM_LEDS-1:0] cnt_pat;
   logic                blink_on;
   logic [15:0]         lfsr;
   logic [NUM_LEDS-1:0] pat_sel;

   assign mode_load = (db_cnt == DB_MAX) && (sync_mode != mode_q);
   assign tick      = (tick_cnt == TICK_MAX);
   assign mode      = mode_q;

   // Two-flop synchroniser feeds a stability counter; a new mode is only
   // accepted once sync_mode has held a different value long enough.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta   <= '0;
         sync_mode   <= '0;
         sync_prev   <= '0;
         db_cnt      <= '0;
         mode_q      <= MODE_CYCLE;
         mode_change <= 1'b0;
      end else begin
         sync_meta   <= sw_mode;
         sync_mode   <= sync_meta;
         sync_prev   <= sync_mode;
         mode_change <= 1'b0;
         if (mode_load) begin
            mode_q      <= mode_e'(sync_mode);
            mode_change <= 1'b1;
            db_cnt      <= '0;
         end else if ((sync_mode == mode_q) || (sync_mode != sync_prev)) begin
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   // A mode change restarts the step timer so the new animation gets a full period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (mode_load || tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // Only the active animation steps; a mode load takes priority over a coincident tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_pat  <= BIT0;
         bnc_pat  <= BIT0;
         bnc_up   <= 1'b1;
         cnt_pat  <= '0;
         blink_on <= 1'b0;
         lfsr     <= LFSR_SEED;
      end else if (mode_load) begin
         cyc_pat  <= BIT0;
         bnc_pat  <= BIT0;
         bnc_up   <= 1'b1;
         cnt_pat  <= '0;
         blink_on <= 1'b0;
         lfsr     <= LFSR_SEED;
      end else if (tick) begin
         case (mode_q)
            MODE_CYCLE: begin
               cyc_pat <= (cyc_pat << 1) | (cyc_pat >> (NUM_LEDS - 1));
            end
            MODE_LFSR: begin
               lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            end
            MODE_BLINK: begin
               blink_on <= ~blink_on;
            end
            MODE_BOUNCE: begin
               // Endpoints turn around immediately so neither end is shown twice.
               if (NUM_LEDS > 1) begin
                  if (bnc_up) begin
                     if (bnc_pat[NUM_LEDS-1]) begin
                        bnc_pat <= bnc_pat >> 1;
                        bnc_up  <= 1'b0;
                     end else begin
                        bnc_pat <= bnc_pat << 1;
                     end
                  end else begin
                     if (bnc_pat[0]) begin
                        bnc_pat <= bnc_pat << 1;
                        bnc_up  <= 1'b1;
                     end else begin
                        bnc_pat <= bnc_pat >> 1;
                     end
                  end
               end
            end
            MODE_COUNT: begin
               cnt_pat <= cnt_pat + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      pat_sel = sw_data;
      case (mode_q)
         MODE_CYCLE:  pat_sel = cyc_pat;
         MODE_LFSR:   pat_sel = lfsr[NUM_LEDS-1:0];
         MODE_BLINK:  pat_sel = {NUM_LEDS{blink_on}};
         MODE_BOUNCE: pat_sel = bnc_pat;
         MODE_COUNT:  pat_sel = cnt_pat;
         default:     pat_sel = sw_data;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led <= '0;
      end else begin
         led <= pat_sel;
      end
   end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomised self-checking bench for led_pattern_sequencer; expected LED
// values come from closed-form per-mode pattern formulas indexed by tick count.
module tb_led_pattern_sequencer;

   localparam int NUM_LEDS        = 4;
   localparam int TICK_DIV        = 4;
   localparam int DEBOUNCE_CYCLES = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] sw_mode = 3'd0;
   logic [3:0] sw_data = 4'd0;
   logic [3:0] led;
   logic [2:0] mode;
   logic       mode_change;

   int tests_run = 0;
   int tests_failed = 0;
   int mc_seen = 0;

   led_pattern_sequencer #(
      .NUM_LEDS(NUM_LEDS),
      .TICK_DIV(TICK_DIV),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sw_mode(sw_mode),
      .sw_data(sw_data),
      .led(led),
      .mode(mode),
      .mode_change(mode_change)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Advance one clock and sample 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (mode_change) mc_seen++;
   endtask

   task automatic wait_mode_change(output int latency, output bit found);
      latency = 0;
      found = 1'b0;
      while (!found && latency < 20) begin
         step();
         latency++;
         if (mode_change) found = 1'b1;
      end
   endtask

   function automatic logic [3:0] lfsr_ref(input int k);
      logic [15:0] s;
      s = 16'hACE1;
      for (int i = 0; i < k; i++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
      return s[3:0];
   endfunction

   // Pattern shown after k ticks in mode m, counted from mode entry.
   function automatic logic [3:0] ref_pattern(input int m, input int k, input logic [3:0] data);
      int p;
      case (m)
         0: return 4'(1 << (k % 4));
         1: return lfsr_ref(k);
         2: return (k % 2 == 1) ? 4'hF : 4'h0;
         3: begin
            p = k % 6;
            if (p > 3) p = 6 - p;
            return 4'(1 << p);
         end
         4: return 4'(k % 16);
         default: return data;
      endcase
   endfunction

   task automatic test_reset();
      sw_mode = 3'd0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (led !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_led: got %h expected 0", led); end
      tests_run++;
      if (mode !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_mode: got %0d expected 0", mode); end
      tests_run++;
      if (mode_change !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mode_change: got %b expected 0", mode_change); end
      step();
      step();
      tests_run++;
      if (led !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_hold_led: got %h expected 0", led); end
      rst_n = 1'b1;
      step();
      tests_run++;
      if (led !== 4'b0001) begin tests_failed++; $display("[TB] FAIL reset_first_edge_led: got %b expected 0001", led); end
   endtask

   task automatic test_cycle();
      logic [3:0] exp;
      sw_mode = 3'd0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      mc_seen = 0;
      for (int j = 1; j <= 24; j++) begin
         step();
         exp = ref_pattern(0, (j - 1) / TICK_DIV, 4'h0);
         tests_run++;
         if (led !== exp) begin tests_failed++; $display("[TB] FAIL cycle_led[%0d]: got %b expected %b", j, led, exp); end
      end
      tests_run++;
      if (mc_seen != 0) begin tests_failed++; $display("[TB] FAIL cycle_no_mode_change: got %0d pulses expected 0", mc_seen); end
   endtask

   task automatic test_bounce();
      int lat;
      bit found;
      logic [3:0] exp;
      mc_seen = 0;
      sw_mode = 3'd3;
      wait_mode_change(lat, found);
      tests_run++;
      if (!found || lat < 5 || lat > 6) begin tests_failed++; $display("[TB] FAIL bounce_latency: got %0d (found=%0d) expected 5..6", lat, found); end
      tests_run++;
      if (mode !== 3'd3) begin tests_failed++; $display("[TB] FAIL bounce_mode: got %0d expected 3", mode); end
      for (int j = 1; j <= 28; j++) begin
         step();
         exp = ref_pattern(3, (j - 1) / TICK_DIV, 4'h0);
         tests_run++;
         if (led !== exp) begin tests_failed++; $display("[TB] FAIL bounce_led[%0d]: got %b expected %b", j, led, exp); end
      end
      tests_run++;
      if (mc_seen != 1) begin tests_failed++; $display("[TB] FAIL bounce_single_pulse: got %0d pulses expected 1", mc_seen); end
   endtask

   task automatic test_glitch();
      logic [3:0] exp;
      sw_mode = 3'd0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      mc_seen = 0;
      for (int j = 1; j <= 32; j++) begin
         step();
         exp = ref_pattern(0, (j - 1) / TICK_DIV, 4'h0);
         tests_run++;
         if (led !== exp) begin tests_failed++; $display("[TB] FAIL glitch_led[%0d]: got %b expected %b", j, led, exp); end
         tests_run++;
         if (mode !== 3'd0) begin tests_failed++; $display("[TB] FAIL glitch_mode[%0d]: got %0d expected 0", j, mode); end
         if (j == 2) sw_mode = 3'd1;
         if (j == 4) sw_mode = 3'd0;
      end
      tests_run++;
      if (mc_seen != 0) begin tests_failed++; $display("[TB] FAIL glitch_no_mode_change: got %0d pulses expected 0", mc_seen); end
   endtask

   task automatic test_lfsr();
      int lat;
      bit found;
      logic [3:0] exp;
      sw_mode = 3'd1;
      wait_mode_change(lat, found);
      tests_run++;
      if (!found || mode !== 3'd1) begin tests_failed++; $display("[TB] FAIL lfsr_enter: got mode %0d (found=%0d) expected 1", mode, found); end
      for (int j = 1; j <= 64 * TICK_DIV; j++) begin
         step();
         exp = ref_pattern(1, (j - 1) / TICK_DIV, 4'h0);
         tests_run++;
         if (led !== exp) begin tests_failed++; $display("[TB] FAIL lfsr_led[%0d]: got %h expected %h", j, led, exp); end
      end
   endtask

   task automatic test_count();
      int lat;
      bit found;
      logic [3:0] exp;
      sw_mode = 3'd4;
      wait_mode_change(lat, found);
      tests_run++;
      if (!found || mode !== 3'd4) begin tests_failed++; $display("[TB] FAIL count_enter: got mode %0d (found=%0d) expected 4", mode, found); end
      for (int j = 1; j <= 18 * TICK_DIV; j++) begin
         step();
         exp = ref_pattern(4, (j - 1) / TICK_DIV, 4'h0);
         tests_run++;
         if (led !== exp) begin tests_failed++; $display("[TB] FAIL count_led[%0d]: got %h expected %h", j, led, exp); end
      end
   endtask

   task automatic test_manual();
      int lat;
      bit found;
      sw_data = 4'b1010;
      sw_mode = 3'd6;
      wait_mode_change(lat, found);
      tests_run++;
      if (!found || mode !== 3'd6) begin tests_failed++; $display("[TB] FAIL manual_enter: got mode %0d (found=%0d) expected 6", mode, found); end
      step();
      tests_run++;
      if (led !== 4'b1010) begin tests_failed++; $display("[TB] FAIL manual_first: got %b expected 1010", led); end
      for (int j = 1; j <= 40; j++) begin
         if ($urandom_range(0, 2) == 0) sw_data = 4'($urandom);
         step();
         tests_run++;
         if (led !== sw_data) begin tests_failed++; $display("[TB] FAIL manual_led[%0d]: got %b expected %b", j, led, sw_data); end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      bit found;
      int m;
      int n;
      logic [3:0] exp;
      for (int r = 0; r < 8; r++) begin
         m = int'($urandom_range(0, 7));
         if (m == int'(mode)) m = (m + 1) % 8;
         sw_data = 4'($urandom);
         sw_mode = 3'(m);
         mc_seen = 0;
         wait_mode_change(lat, found);
         tests_run++;
         if (!found || lat < 5 || lat > 6) begin tests_failed++; $display("[TB] FAIL b2b_latency[%0d]: got %0d (found=%0d) expected 5..6", r, lat, found); end
         tests_run++;
         if (mode !== 3'(m)) begin tests_failed++; $display("[TB] FAIL b2b_mode[%0d]: got %0d expected %0d", r, mode, m); end
         n = int'($urandom_range(8, 40));
         for (int j = 1; j <= n; j++) begin
            step();
            exp = ref_pattern(m, (j - 1) / TICK_DIV, sw_data);
            tests_run++;
            if (led !== exp) begin tests_failed++; $display("[TB] FAIL b2b_led[%0d/%0d] mode %0d: got %h expected %h", r, j, m, led, exp); end
            sw_data = 4'($urandom);
         end
         tests_run++;
         if (mc_seen != 1) begin tests_failed++; $display("[TB] FAIL b2b_pulses[%0d]: got %0d expected 1", r, mc_seen); end
      end
   endtask

   task automatic test_async_reset();
      int lat;
      bit found;
      int guard;
      logic [3:0] exp;
      sw_mode = 3'd2;
      wait_mode_change(lat, found);
      tests_run++;
      if (!found || mode !== 3'd2) begin tests_failed++; $display("[TB] FAIL areset_enter: got mode %0d (found=%0d) expected 2", mode, found); end
      guard = 0;
      while (led !== 4'hF && guard < 20) begin
         step();
         guard++;
      end
      tests_run++;
      if (led !== 4'hF) begin tests_failed++; $display("[TB] FAIL areset_blink_on: got %h expected F", led); end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (led !== 4'h0) begin tests_failed++; $display("[TB] FAIL areset_led: got %h expected 0", led); end
      tests_run++;
      if (mode !== 3'd0) begin tests_failed++; $display("[TB] FAIL areset_mode: got %0d expected 0", mode); end
      step();
      rst_n = 1'b1;
      mc_seen = 0;
      wait_mode_change(lat, found);
      tests_run++;
      if (!found || lat < 5 || lat > 6) begin tests_failed++; $display("[TB] FAIL areset_relatch: got %0d (found=%0d) expected 5..6", lat, found); end
      tests_run++;
      if (mode !== 3'd2) begin tests_failed++; $display("[TB] FAIL areset_mode_after: got %0d expected 2", mode); end
      for (int j = 1; j <= 12; j++) begin
         step();
         exp = ref_pattern(2, (j - 1) / TICK_DIV, 4'h0);
         tests_run++;
         if (led !== exp) begin tests_failed++; $display("[TB] FAIL areset_blink[%0d]: got %h expected %h", j, led, exp); end
      end
   endtask

   initial begin
      test_reset();
      test_cycle();
      test_bounce();
      test_glitch();
      test_lfsr();
      test_count();
      test_manual();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
